// File: rtl/cpu_pkg.sv
// Shared types for the CPU_V1 front end: PC word, fetch FSM states and
// the next-PC select encoding used between the FSM and the PC datapath.
package cpu_pkg;

    typedef logic [31:0] pc_t;

    localparam int PC_STEP = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT,
        ERROR
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_SEQ,
        PC_BRANCH
    } pc_sel_t;

    // First byte address past the instruction-memory window.
    function automatic pc_t window_limit(input int unsigned words);
        return pc_t'(PC_STEP * words);
    endfunction

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC selection with window wrap, plus the alignment and
// range check applied to branch targets.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  pc_t     pc,
    input  pc_sel_t pc_sel,
    input  pc_t     branch_target,
    output pc_t     pc_next,
    output logic    target_bad
);

    localparam pc_t LIMIT = window_limit(IMEM_WORDS);

    pc_t pc_inc;
    pc_t pc_seq;

    assign pc_inc = pc + pc_t'(PC_STEP);

    // Compare with >= so a PC that somehow sits past the window still wraps.
    assign pc_seq = (pc_inc >= LIMIT) ? '0 : pc_inc;

    assign target_bad = (branch_target[1:0] != 2'b00) || (branch_target >= LIMIT);

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_SEQ:    pc_next = pc_seq;
            PC_BRANCH: pc_next = branch_target;
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for CPU_V1: fetch handshake FSM, PC register and
// retired-instruction counter. All outputs come straight from registers.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter pc_t RESET_PC   = 32'h0000_0000,
    parameter int  IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    input  logic        resume,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired_count
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    pc_t          pc_reg;
    pc_t          pc_next;
    pc_sel_t      pc_sel;
    logic         target_bad;
    logic         retire;
    logic         instr_valid_reg;
    logic [31:0]  retired_count_reg;

    pc_next_unit #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_next (
        .pc            (pc_reg),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .target_bad    (target_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            pc_reg            <= RESET_PC;
            instr_valid_reg   <= 1'b0;
            retired_count_reg <= '0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            instr_valid_reg   <= retire;
            if (retire) begin
                retired_count_reg <= retired_count_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_sel     = PC_HOLD;
        retire     = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // A stalled instruction ignores halt and branch entirely.
                if (!stall) begin
                    if (branch_taken && target_bad) begin
                        state_next = ERROR;
                    end else begin
                        retire = 1'b1;
                        if (halt) begin
                            state_next = HALT;
                            pc_sel     = PC_SEQ;
                        end else if (branch_taken) begin
                            state_next = FETCH;
                            pc_sel     = PC_BRANCH;
                        end else begin
                            state_next = FETCH;
                            pc_sel     = PC_SEQ;
                        end
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_next = FETCH;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc            = pc_reg;
    assign fetch_req     = (state_reg == FETCH);
    assign halted        = (state_reg == HALT);
    assign fault         = (state_reg == ERROR);
    assign instr_valid   = instr_valid_reg;
    assign retired_count = retired_count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table for the documented scenarios, then randomized
// stimulus compared every cycle against a transaction-level model.
module tb_fetch_sequencer;

    localparam int          WORDS  = 64;
    localparam logic [31:0] WINDOW = 32'd256;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic        resume;
    logic        imem_ready;
    logic [31:0] pc;
    logic        fetch_req;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;

    int n_vec;
    int n_miss;

    fetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .resume        (resume),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .fetch_req     (fetch_req),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .fault         (fault),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r, st, bt;
        logic [31:0] tgt;
        logic        h, res, rdy;
        logic [31:0] e_pc;
        logic        e_fr, e_iv, e_hl, e_ft;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: where the machine is in an instruction's life.
    localparam int P_IDLE = 0, P_WAIT_MEM = 1, P_RUN = 2, P_PARKED = 3, P_DEAD = 4;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_pulse;

    function automatic vec_t mk(logic r, logic st, logic bt, logic [31:0] tgt, logic h,
                                logic res, logic rdy, logic [31:0] e_pc, logic e_fr,
                                logic e_iv, logic e_hl, logic e_ft, logic [31:0] e_cnt);
        vec_t v;
        v.r = r; v.st = st; v.bt = bt; v.tgt = tgt; v.h = h; v.res = res; v.rdy = rdy;
        v.e_pc = e_pc; v.e_fr = e_fr; v.e_iv = e_iv; v.e_hl = e_hl; v.e_ft = e_ft;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic model_step(logic r, logic st, logic bt, logic [31:0] tgt, logic h,
                              logic res, logic rdy);
        m_pulse = 1'b0;
        if (r) begin
            m_phase = P_IDLE;
            m_pc    = 32'h0;
            m_count = 32'h0;
            return;
        end
        case (m_phase)
            P_IDLE:     m_phase = P_WAIT_MEM;
            P_WAIT_MEM: if (rdy) m_phase = P_RUN;
            P_RUN: begin
                if (!st) begin
                    if (bt && ((tgt % 4) != 0 || tgt >= WINDOW)) begin
                        m_phase = P_DEAD;
                    end else begin
                        m_pulse = 1'b1;
                        m_count = m_count + 1;
                        if (h) begin
                            m_pc    = (m_pc + 4) % WINDOW;
                            m_phase = P_PARKED;
                        end else if (bt) begin
                            m_pc    = tgt;
                            m_phase = P_WAIT_MEM;
                        end else begin
                            m_pc    = (m_pc + 4) % WINDOW;
                            m_phase = P_WAIT_MEM;
                        end
                    end
                end
            end
            P_PARKED:   if (res) m_phase = P_WAIT_MEM;
            default:    ;
        endcase
    endtask

    task automatic cycle(logic r, logic st, logic bt, logic [31:0] tgt, logic h,
                         logic res, logic rdy);
        reset = r; stall = st; branch_taken = bt; branch_target = tgt;
        halt = h; resume = res; imem_ready = rdy;
        @(posedge clk);
        model_step(r, st, bt, tgt, h, res, rdy);
        @(negedge clk);
    endtask

    task automatic check(string tag, logic [31:0] e_pc, logic e_fr, logic e_iv,
                         logic e_hl, logic e_ft, logic [31:0] e_cnt);
        n_vec++;
        if (pc !== e_pc) begin
            n_miss++; $display("FAIL %s pc: got %h want %h", tag, pc, e_pc);
        end
        if (fetch_req !== e_fr) begin
            n_miss++; $display("FAIL %s fetch_req: got %b want %b", tag, fetch_req, e_fr);
        end
        if (instr_valid !== e_iv) begin
            n_miss++; $display("FAIL %s instr_valid: got %b want %b", tag, instr_valid, e_iv);
        end
        if (halted !== e_hl) begin
            n_miss++; $display("FAIL %s halted: got %b want %b", tag, halted, e_hl);
        end
        if (fault !== e_ft) begin
            n_miss++; $display("FAIL %s fault: got %b want %b", tag, fault, e_ft);
        end
        if (retired_count !== e_cnt) begin
            n_miss++; $display("FAIL %s retired_count: got %0d want %0d", tag, retired_count, e_cnt);
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        m_phase = P_IDLE; m_pc = '0; m_count = '0; m_pulse = 1'b0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        halt = 1'b0; resume = 1'b0; imem_ready = 1'b0;

        //                r  st bt tgt          h  res rdy   pc           fr iv hl ft cnt
        vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 0,    32'h00, 0, 0, 0, 0, 0));  // reset
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 1, 0, 0, 0, 0));  // IDLE->FETCH
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 0, 0, 0, 0, 0));  // ->EXEC
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h04, 1, 1, 0, 0, 1));  // retire 0
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h04, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)                                                    // stall x3
            vecs.push_back(mk(0, 1, 1, 32'h80,  1, 0, 1,    32'h04, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 0,    32'h08, 1, 1, 0, 0, 2));  // retire 4
        for (int i = 0; i < 5; i++)                                                    // imem not ready
            vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0,    32'h08, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h08, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h40,      0, 0, 1,    32'h40, 1, 1, 0, 0, 3));  // branch 0x40
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h40, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 32'hFC,      0, 0, 1,    32'hFC, 1, 1, 0, 0, 4));  // branch 0xFC
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'hFC, 0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 1, 1, 0, 0, 5));  // wrap
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, 1, 32'h10,      0, 0, 1,    32'h10, 1, 1, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h10, 0, 0, 0, 0, 6));
        vecs.push_back(mk(0, 0, 1, 32'h80,      1, 0, 1,    32'h14, 0, 1, 1, 0, 7));  // halt+branch
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h14, 0, 0, 1, 0, 7));  // parked
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 1, 0,    32'h14, 1, 0, 0, 0, 7));  // resume
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h14, 0, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, 1, 32'h100,     0, 0, 1,    32'h14, 0, 0, 0, 1, 7));  // out of range
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 1, 1,    32'h14, 0, 0, 0, 1, 7));  // sticky
        vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 0,    32'h00, 0, 0, 0, 0, 0));  // reset clears
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h42,      0, 0, 1,    32'h00, 0, 0, 0, 1, 0));  // misaligned
        vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 0,    32'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 0,    32'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 1,    32'h00, 0, 0, 0, 0, 0));  // reset mid-FETCH
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 1,    32'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 1,    32'h00, 0, 0, 0, 0, 0));  // reset in EXEC
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 0,    32'h00, 1, 0, 0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].st, vecs[i].bt, vecs[i].tgt, vecs[i].h, vecs[i].res,
                  vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fr, vecs[i].e_iv,
                  vecs[i].e_hl, vecs[i].e_ft, vecs[i].e_cnt);
        end

        for (int i = 0; i < 3000; i++) begin
            logic        r, st, bt, h, res, rdy;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 7) == 0);
            res = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       tgt = $urandom_range(0, 255) | 32'h1;
                1:       tgt = 32'h100 + 32'($urandom_range(0, 63) * 4);
                2:       tgt = 32'hFC;
                default: tgt = 32'($urandom_range(0, 63) * 4);
            endcase
            cycle(r, st, bt, tgt, h, res, rdy);
            check($sformatf("rnd%0d", i), m_pc, (m_phase == P_WAIT_MEM), m_pulse,
                  (m_phase == P_PARKED), (m_phase == P_DEAD), m_count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
